bus_router: RTL and testbench
=============================

BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 SHALL have parameter SLAVE_CNT, default 4: number of slave ports, legal range 1..8.
REQ-002 SHALL have parameter SLAVE_BASE, default {NOR,SRAM,TCM,ROM}_BASE: SLAVE_CNT*`XLEN bits, slave i base at bits [i*`XLEN +: `XLEN].
REQ-003 SHALL have parameter SLAVE_SPAN, default {clog2 of NOR,SRAM,TCM,ROM size}: SLAVE_CNT*6 bits, slave i address span in bits at [i*6 +: 6].
REQ-004 SHALL have parameter TIMEOUT_CYC, default `BUS_TIMEOUT_CYC (256): WAIT cycles before timeout, legal range 2..65535.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 Ports:
  clk  in  1  clock;
  rst  in  1  synchronous active-high reset;
  m_req  in  1  master request pulse;
  m_addr  in  `XLEN  address;
  m_w_rb  in  1  write/read_bar;
  m_acc  in  $clog2(`BUS_ACC_CNT)  access size;
  m_wdata  in  `BUS_WIDTH  write data;
  m_resp  out  1  response;
  m_rdata  out  `BUS_WIDTH  read data;
  s_req  out  SLAVE_CNT  per-slave request;
  s_addr/s_w_rb/s_acc/s_wdata  out  SLAVE_CNT x field width  broadcast copies of master fields;
  s_resp  in  SLAVE_CNT  per-slave response;
  s_rdata  in  SLAVE_CNT*`BUS_WIDTH  per-slave read data;
  bus_fault  out  1  fault pulse;
  bus_fault_addr  out  `XLEN  faulting address;
  bus_fault_tmo  out  1  fault cause is timeout;
  bus_halt  in  1  force halt.

Function
REQ-007 Decode SHALL hit slave i when (m_addr & ~((1<<span_i)-1)) == base_i; on multiple hits, lowest index wins.
REQ-008 FSM SHALL have two states: IDLE and WAIT.
REQ-009 IDLE: m_req & hit & ~bus_halt SHALL assert s_req[sel] in the same cycle (zero latency) and latch sel index and m_addr.
REQ-010 IDLE: if s_resp[sel] is also high that cycle, the FSM SHALL stay IDLE and complete. Otherwise it SHALL go to WAIT.
REQ-011 WAIT: only s_resp[latched sel] SHALL be honoured. Responses from other slaves SHALL be ignored.
REQ-012 WAIT: m_req SHALL be ignored (no s_req) except in the cycle where the latched slave responds; that request SHALL be handled as in IDLE (back-to-back).
REQ-013 m_resp SHALL equal honoured response & ~bus_halt.
REQ-014 A response arriving under bus_halt SHALL be dropped: the FSM returns to IDLE and m_resp stays 0.
REQ-015 m_rdata SHALL pass through s_rdata[sel] in the response cycle. In all other cycles it SHALL hold the last returned value in a register (no latch).
REQ-016 A decode miss (m_req, no hit, IDLE or back-to-back slot) SHALL drive bus_fault=1 in that cycle, bus_fault_addr=m_addr, bus_fault_tmo=0, and no s_req.
REQ-017 bus_halt SHALL suppress new s_req; it SHALL NOT suppress decode faults.

Reset
REQ-018 rst SHALL force IDLE, sel=0, latched addr=0, m_rdata register=0, timeout counter=0.
REQ-019 Under rst, s_req=0, m_resp=0, bus_fault=0 and bus_fault_tmo=0; an in-flight transaction SHALL be abandoned silently.

Configuration
REQ-020 With BUS_ROUTER_TIMEOUT_EN defined, a counter SHALL increment each WAIT cycle and clear on entry to WAIT.
REQ-021 When that counter reaches TIMEOUT_CYC-1 without a response, the block SHALL pulse bus_fault=1 and bus_fault_tmo=1 for one cycle, drive bus_fault_addr=latched addr, and return to IDLE; a slave response in that same cycle SHALL win (no fault).
REQ-022 Without BUS_ROUTER_TIMEOUT_EN, there SHALL be no counter, WAIT SHALL persist until a response arrives, and bus_fault_tmo SHALL be tied 0.

Structure
REQ-023 `BUS_TIMEOUT_CYC and the FSM state encodings SHALL live in femto.vh.
REQ-024 The block SHALL have one sub-module, bus_addr_dec: combinational decode producing a one-hot hit vector, a binary index and a miss flag.

Verification
REQ-025 Read ROM at 0x0 with a same-cycle response (0xDEADBEEF) -> m_resp in the same cycle, m_rdata=0xDEADBEEF, FSM stays IDLE.
REQ-026 SRAM read with 3-cycle latency; TCM s_resp pulses spuriously during the wait -> TCM pulse ignored, m_resp exactly on the SRAM response, m_rdata held afterwards.
REQ-027 m_req to unmapped 0xF0000000 -> bus_fault=1 for one cycle, bus_fault_addr=0xF0000000, bus_fault_tmo=0, s_req=0.
REQ-028 TIMEOUT_EN, TIMEOUT_CYC=4, NOR never responds -> bus_fault and bus_fault_tmo pulse after the 4th WAIT cycle with the NOR address; the next request is accepted.
REQ-029 bus_halt high during WAIT when the response arrives -> m_resp=0, FSM returns to IDLE; rst asserted mid-WAIT -> all outputs 0 on the next cycle.
REQ-030 Back-to-back: a new TCM m_req in the SRAM response cycle -> s_req[TCM] asserted in that same cycle.

Source files
------------

// File: rtl/bus_router_pkg.sv
// Shared bus defines (the femto.vh set: widths, memory map, timeout, FSM encodings)
// and the router package with state type and default slave map.
`ifndef BUS_ROUTER_FEMTO_DEFS
`define BUS_ROUTER_FEMTO_DEFS
`define XLEN            32
`define BUS_WIDTH       32
`define BUS_ACC_CNT     3
`define BUS_TIMEOUT_CYC 256
`define ROM_BASE        32'h0000_0000
`define TCM_BASE        32'h1000_0000
`define SRAM_BASE       32'h2000_0000
`define NOR_BASE        32'h3000_0000
`define ROM_SIZE_LOG2   6'd16
`define TCM_SIZE_LOG2   6'd16
`define SRAM_SIZE_LOG2  6'd17
`define NOR_SIZE_LOG2   6'd24
`define BUS_ST_IDLE     1'b0
`define BUS_ST_WAIT     1'b1
`endif

package bus_router_pkg;
  localparam int XLEN            = `XLEN;
  localparam int BUS_WIDTH       = `BUS_WIDTH;
  localparam int ACC_W           = $clog2(`BUS_ACC_CNT);
  localparam int BUS_TIMEOUT_CYC = `BUS_TIMEOUT_CYC;

  typedef enum logic {
    ST_IDLE = `BUS_ST_IDLE,
    ST_WAIT = `BUS_ST_WAIT
  } state_t;

  // Slave 0 sits in the low bits: ROM=0, TCM=1, SRAM=2, NOR=3.
  localparam logic [4*XLEN-1:0] DEF_BASE = {`NOR_BASE, `SRAM_BASE, `TCM_BASE, `ROM_BASE};
  localparam logic [4*6-1:0]    DEF_SPAN = {`NOR_SIZE_LOG2, `SRAM_SIZE_LOG2,
                                            `TCM_SIZE_LOG2, `ROM_SIZE_LOG2};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_addr_dec.sv
// Combinational slave address decoder: one-hot hit (lowest index wins),
// binary index of the winner and a miss flag.
module bus_addr_dec
  import bus_router_pkg::*;
#(
  parameter int                          SLAVE_CNT  = 4,
  parameter logic [SLAVE_CNT*XLEN-1:0]   SLAVE_BASE = (SLAVE_CNT*XLEN)'(DEF_BASE),
  parameter logic [SLAVE_CNT*6-1:0]      SLAVE_SPAN = (SLAVE_CNT*6)'(DEF_SPAN),
  parameter int                          IW         = idx_width(SLAVE_CNT)
) (
  input  logic [XLEN-1:0]      addr,
  output logic [SLAVE_CNT-1:0] hit,
  output logic [IW-1:0]        idx,
  output logic                 miss
);
  logic [63:0] mask;
  logic        found;

  always_comb begin
    hit   = '0;
    idx   = '0;
    found = 1'b0;
    mask  = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      mask = ~((64'd1 << SLAVE_SPAN[i*6 +: 6]) - 64'd1);
      if (!found && ((addr & mask[XLEN-1:0]) == SLAVE_BASE[i*XLEN +: XLEN])) begin
        hit[i] = 1'b1;
        idx    = IW'(i);
        found  = 1'b1;
      end
    end
    miss = !found;
  end
endmodule

// File: rtl/bus_router.sv
// Single-master to multi-slave bus router with zero-latency request issue.
// Optional WAIT timeout fault is enabled by defining BUS_ROUTER_TIMEOUT_EN.
module bus_router
  import bus_router_pkg::*;
#(
  parameter int                        SLAVE_CNT   = 4,
  parameter logic [SLAVE_CNT*XLEN-1:0] SLAVE_BASE  = (SLAVE_CNT*XLEN)'(DEF_BASE),
  parameter logic [SLAVE_CNT*6-1:0]    SLAVE_SPAN  = (SLAVE_CNT*6)'(DEF_SPAN),
  parameter int                        TIMEOUT_CYC = BUS_TIMEOUT_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           m_req,
  input  logic [XLEN-1:0]                m_addr,
  input  logic                           m_w_rb,
  input  logic [ACC_W-1:0]               m_acc,
  input  logic [BUS_WIDTH-1:0]           m_wdata,
  output logic                           m_resp,
  output logic [BUS_WIDTH-1:0]           m_rdata,
  output logic [SLAVE_CNT-1:0]           s_req,
  output logic [SLAVE_CNT*XLEN-1:0]      s_addr,
  output logic [SLAVE_CNT-1:0]           s_w_rb,
  output logic [SLAVE_CNT*ACC_W-1:0]     s_acc,
  output logic [SLAVE_CNT*BUS_WIDTH-1:0] s_wdata,
  input  logic [SLAVE_CNT-1:0]           s_resp,
  input  logic [SLAVE_CNT*BUS_WIDTH-1:0] s_rdata,
  output logic                           bus_fault,
  output logic [XLEN-1:0]                bus_fault_addr,
  output logic                           bus_fault_tmo,
  input  logic                           bus_halt
);
  localparam int IW = idx_width(SLAVE_CNT);

  state_t               state, state_n;
  logic [IW-1:0]        sel_q, dec_idx;
  logic [XLEN-1:0]      addr_q;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_n;
  logic [SLAVE_CNT-1:0] dec_hit;
  logic                 dec_miss;
  logic                 wait_resp, slot, start, new_resp, resp_hon, dec_fault, tmo_fault;

  bus_addr_dec #(
    .SLAVE_CNT  (SLAVE_CNT),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SPAN (SLAVE_SPAN),
    .IW         (IW)
  ) u_dec (
    .addr (m_addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  // A new request may be taken in IDLE or in the cycle the latched slave answers.
  assign wait_resp = (state == ST_WAIT) && s_resp[sel_q];
  assign slot      = (state == ST_IDLE) || wait_resp;
  assign start     = slot && m_req && !dec_miss && !bus_halt;
  assign new_resp  = start && s_resp[dec_idx];
  assign dec_fault = slot && m_req && dec_miss;
  assign resp_hon  = (wait_resp && !bus_halt) || new_resp;

`ifdef BUS_ROUTER_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst)                    tmo_cnt <= '0;
    else if (slot)              tmo_cnt <= '0;
    else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + 16'd1;
  end

  assign tmo_fault = (state == ST_WAIT) && !s_resp[sel_q] &&
                     (tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign tmo_fault = 1'b0;
`endif

  always_comb begin
    state_n = state;
    rdata_n = rdata_q;
    if (slot)           state_n = (start && !new_resp) ? ST_WAIT : ST_IDLE;
    else if (tmo_fault) state_n = ST_IDLE;
    if (wait_resp && !bus_halt) rdata_n = s_rdata[sel_q*BUS_WIDTH +: BUS_WIDTH];
    else if (new_resp)          rdata_n = s_rdata[dec_idx*BUS_WIDTH +: BUS_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_n;
      rdata_q <= rdata_n;
      if (start) begin
        sel_q  <= dec_idx;
        addr_q <= m_addr;
      end
    end
  end

  assign m_resp         = resp_hon && !rst;
  assign m_rdata        = rst ? '0 : rdata_n;
  assign s_req          = (start && !rst) ? dec_hit : '0;
  assign s_addr         = {SLAVE_CNT{m_addr}};
  assign s_w_rb         = {SLAVE_CNT{m_w_rb}};
  assign s_acc          = {SLAVE_CNT{m_acc}};
  assign s_wdata        = {SLAVE_CNT{m_wdata}};
  assign bus_fault      = (dec_fault || tmo_fault) && !rst;
  assign bus_fault_tmo  = tmo_fault && !rst;
  assign bus_fault_addr = rst       ? '0     :
                          tmo_fault ? addr_q :
                          dec_fault ? m_addr : '0;
endmodule

// File: tb/tb_bus_router.sv
// Directed testbench for bus_router (ROM=0, TCM=1, SRAM=2, NOR=3; TIMEOUT_CYC=4).
// The timeout scenario follows BUS_ROUTER_TIMEOUT_EN.
module tb_bus_router;
  logic         clk = 1'b0;
  logic         rst;
  logic         m_req;
  logic [31:0]  m_addr;
  logic         m_w_rb;
  logic [1:0]   m_acc;
  logic [31:0]  m_wdata;
  logic         m_resp;
  logic [31:0]  m_rdata;
  logic [3:0]   s_req;
  logic [127:0] s_addr;
  logic [3:0]   s_w_rb;
  logic [7:0]   s_acc;
  logic [127:0] s_wdata;
  logic [3:0]   s_resp;
  logic [127:0] s_rdata;
  logic         bus_fault;
  logic [31:0]  bus_fault_addr;
  logic         bus_fault_tmo;
  logic         bus_halt;

  int tests_run = 0;
  int tests_failed = 0;

  bus_router #(.SLAVE_CNT(4), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_w_rb(m_w_rb),
    .m_acc(m_acc), .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_w_rb(s_w_rb), .s_acc(s_acc),
    .s_wdata(s_wdata), .s_resp(s_resp), .s_rdata(s_rdata), .bus_fault(bus_fault),
    .bus_fault_addr(bus_fault_addr), .bus_fault_tmo(bus_fault_tmo), .bus_halt(bus_halt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [31:0] addr,
                               input logic [3:0] resp, input logic halt);
    m_req    = req;
    m_addr   = addr;
    s_resp   = resp;
    bus_halt = halt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; m_w_rb = 1'b0; m_acc = 2'd2; m_wdata = 32'h0;
    s_rdata = '0;
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0);
    tick(); tick();
    checkOutput("rst_sreq",  {28'd0, s_req}, 32'h0);
    checkOutput("rst_mresp", {31'd0, m_resp}, 32'h0);
    checkOutput("rst_fault", {31'd0, bus_fault}, 32'h0);
    checkOutput("rst_rdata", m_rdata, 32'h0);
    rst = 1'b0;
    tick();

    // ROM read answered in the same cycle
    s_rdata[0*32 +: 32] = 32'hDEADBEEF;
    applyStimulus(1'b1, 32'h0000_0000, 4'b0001, 1'b0);
    checkOutput("rom_sreq",  {28'd0, s_req}, 32'h1);
    checkOutput("rom_mresp", {31'd0, m_resp}, 32'h1);
    checkOutput("rom_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0);
    checkOutput("rom_hold", m_rdata, 32'hDEADBEEF);
    checkOutput("rom_idle_resp", {31'd0, m_resp}, 32'h0);

    // SRAM read, 3-cycle latency, spurious TCM response and an ignored request
    applyStimulus(1'b1, 32'h2000_0040, 4'b0000, 1'b0);
    checkOutput("sram_sreq", {28'd0, s_req}, 32'h4);
    checkOutput("sram_noresp", {31'd0, m_resp}, 32'h0);
    tick();
    s_rdata[1*32 +: 32] = 32'h1111_1111;
    applyStimulus(1'b0, 32'h0, 4'b0010, 1'b0);
    checkOutput("sram_tcm_spur", {31'd0, m_resp}, 32'h0);
    checkOutput("sram_tcm_rdata", m_rdata, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b1, 32'h0000_0010, 4'b0000, 1'b0);
    checkOutput("sram_wait_noreq", {28'd0, s_req}, 32'h0);
    tick();
    s_rdata[2*32 +: 32] = 32'hCAFEF00D;
    applyStimulus(1'b0, 32'h0, 4'b0100, 1'b0);
    checkOutput("sram_mresp", {31'd0, m_resp}, 32'h1);
    checkOutput("sram_rdata", m_rdata, 32'hCAFEF00D);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0);
    checkOutput("sram_hold", m_rdata, 32'hCAFEF00D);

    // Unmapped address
    applyStimulus(1'b1, 32'hF000_0000, 4'b0000, 1'b0);
    checkOutput("miss_fault", {31'd0, bus_fault}, 32'h1);
    checkOutput("miss_addr",  bus_fault_addr, 32'hF000_0000);
    checkOutput("miss_tmo",   {31'd0, bus_fault_tmo}, 32'h0);
    checkOutput("miss_sreq",  {28'd0, s_req}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0);
    checkOutput("miss_pulse", {31'd0, bus_fault}, 32'h0);

    // Back-to-back SRAM then TCM
    applyStimulus(1'b1, 32'h2000_0000, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h1000_0010, 4'b0100, 1'b0);
    checkOutput("b2b_mresp", {31'd0, m_resp}, 32'h1);
    checkOutput("b2b_sreq",  {28'd0, s_req}, 32'h2);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0100, 1'b0);
    checkOutput("b2b_other_ign", {31'd0, m_resp}, 32'h0);
    tick();
    s_rdata[1*32 +: 32] = 32'h2222_2222;
    applyStimulus(1'b0, 32'h0, 4'b0010, 1'b0);
    checkOutput("b2b_tcm_resp",  {31'd0, m_resp}, 32'h1);
    checkOutput("b2b_tcm_rdata", m_rdata, 32'h2222_2222);
    tick();

    // Response dropped under halt, then router is back in IDLE
    applyStimulus(1'b1, 32'h3000_0000, 4'b0000, 1'b0);
    checkOutput("nor_sreq", {28'd0, s_req}, 32'h8);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b1000, 1'b1);
    checkOutput("halt_mresp", {31'd0, m_resp}, 32'h0);
    checkOutput("halt_rdata", m_rdata, 32'h2222_2222);
    tick();
    s_rdata[0*32 +: 32] = 32'h3333_3333;
    applyStimulus(1'b1, 32'h0000_0100, 4'b0001, 1'b0);
    checkOutput("halt_idle_resp",  {31'd0, m_resp}, 32'h1);
    checkOutput("halt_idle_rdata", m_rdata, 32'h3333_3333);
    tick();
    applyStimulus(1'b1, 32'h0000_0100, 4'b0000, 1'b1);
    checkOutput("halt_no_sreq", {28'd0, s_req}, 32'h0);
    applyStimulus(1'b1, 32'hF000_0004, 4'b0000, 1'b1);
    checkOutput("halt_fault", {31'd0, bus_fault}, 32'h1);
    tick();

    // Reset mid-WAIT abandons the transaction
    applyStimulus(1'b1, 32'h2000_0000, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstw_sreq",  {28'd0, s_req}, 32'h0);
    checkOutput("rstw_mresp", {31'd0, m_resp}, 32'h0);
    checkOutput("rstw_fault", {31'd0, bus_fault}, 32'h0);
    checkOutput("rstw_rdata", m_rdata, 32'h0);
    applyStimulus(1'b0, 32'h0, 4'b0100, 1'b0);
    checkOutput("rstw_late_resp", {31'd0, m_resp}, 32'h0);
    tick();

    // NOR never answers
    applyStimulus(1'b1, 32'h3000_1234, 4'b0000, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0);
`ifdef BUS_ROUTER_TIMEOUT_EN
    for (int w = 1; w <= 3; w++) begin
      checkOutput($sformatf("tmo_quiet_w%0d", w), {31'd0, bus_fault}, 32'h0);
      tick();
    end
    checkOutput("tmo_fault", {31'd0, bus_fault}, 32'h1);
    checkOutput("tmo_flag",  {31'd0, bus_fault_tmo}, 32'h1);
    checkOutput("tmo_addr",  bus_fault_addr, 32'h3000_1234);
    tick();
    checkOutput("tmo_pulse", {31'd0, bus_fault}, 32'h0);
    s_rdata[0*32 +: 32] = 32'h4444_4444;
    applyStimulus(1'b1, 32'h0000_0000, 4'b0001, 1'b0);
    checkOutput("tmo_next_sreq",  {28'd0, s_req}, 32'h1);
    checkOutput("tmo_next_mresp", {31'd0, m_resp}, 32'h1);
`else
    for (int w = 1; w <= 10; w++) begin
      checkOutput($sformatf("wait_quiet_w%0d", w), {30'd0, bus_fault, bus_fault_tmo}, 32'h0);
      tick();
    end
    s_rdata[3*32 +: 32] = 32'h5555_5555;
    applyStimulus(1'b0, 32'h0, 4'b1000, 1'b0);
    checkOutput("wait_nor_resp",  {31'd0, m_resp}, 32'h1);
    checkOutput("wait_nor_rdata", m_rdata, 32'h5555_5555);
`endif
    tick();
    applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
